// File: rtl/violation_reset_ctrl.sv
// rtl/violation_reset_ctrl.sv - turns monitor violation requests into a held CPU reset released at the reset handler
// Optional VIOL_CNT_EN adds the 8-bit saturating kill-episode counter on viol_cnt.
module violation_reset_ctrl #(
   parameter int          NUM_SRC       = 3,
   parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
   parameter int          MIN_HOLD      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        pc,
   input  logic [NUM_SRC-1:0] viol_req,
   output logic               reset,
   output logic [NUM_SRC-1:0] cause,
   output logic [7:0]         viol_cnt,
   output logic               active
);

   typedef enum logic [1:0] {RUN, HOLD, WAIT_PC} state_t;

   localparam logic [7:0] HOLD_INIT = 8'(MIN_HOLD - 1);

   state_t             state, state_next;
   logic [7:0]         hold_cnt, hold_next;
   logic [NUM_SRC-1:0] cause_next;
   logic               any_req;
   logic               release_ok;

   assign any_req    = |viol_req;
   assign release_ok = (pc == RESET_HANDLER) && !any_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         hold_cnt <= 8'h00;
         cause    <= '0;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_next;
         cause    <= cause_next;
      end
   end

   // The last HOLD cycle already evaluates the release condition, so the
   // minimum assertion is exactly MIN_HOLD+1 cycles including the request cycle.
   always_comb begin
      state_next = state;
      hold_next  = hold_cnt;
      cause_next = cause;
      reset      = 1'b0;
      case (state)
         RUN: begin
            reset = any_req;
            if (any_req) begin
               cause_next = viol_req;
               hold_next  = HOLD_INIT;
               state_next = HOLD;
            end
         end
         HOLD: begin
            reset      = 1'b1;
            cause_next = cause | viol_req;
            if (hold_cnt == 8'h00) begin
               state_next = release_ok ? RUN : WAIT_PC;
            end else begin
               hold_next = hold_cnt - 8'h01;
            end
         end
         WAIT_PC: begin
            reset      = 1'b1;
            cause_next = cause | viol_req;
            if (release_ok) begin
               state_next = RUN;
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase
      if (rst) begin
         reset = 1'b0;
      end
   end

   assign active = !rst && (state != RUN);

`ifdef VIOL_CNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 8'h00;
      end else if ((state == RUN) && any_req && (cnt_q != 8'hFF)) begin
         cnt_q <= cnt_q + 8'h01;
      end
   end

   assign viol_cnt = cnt_q;
`else
   assign viol_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_violation_reset_ctrl.sv
// tb/tb_violation_reset_ctrl.sv - directed vector bench for violation_reset_ctrl
module tb_violation_reset_ctrl;

   localparam logic [15:0] H = 16'hFFFE;
   localparam logic [15:0] A = 16'hA010;
`ifdef VIOL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc;
   logic [2:0]  viol_req;
   logic        reset;
   logic [2:0]  cause;
   logic [7:0]  viol_cnt;
   logic        active;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   violation_reset_ctrl #(
      .NUM_SRC      (3),
      .RESET_HANDLER(16'hFFFE),
      .MIN_HOLD     (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pc      (pc),
      .viol_req(viol_req),
      .reset   (reset),
      .cause   (cause),
      .viol_cnt(viol_cnt),
      .active  (active)
   );

   typedef struct {
      logic        rst;
      logic [15:0] pc;
      logic [2:0]  req;
      logic        r;
      logic [2:0]  c;
      int          n;
      logic        a;
   } vec_t;

   vec_t tbl[27];

   function automatic logic [7:0] ecnt(input int n);
      if (!CNT_EN) return 8'h00;
      return (n > 255) ? 8'hFF : 8'(n);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Inputs are applied just after a rising edge; outputs are sampled at the falling edge.
   task automatic drive(input logic r, input logic [15:0] p, input logic [2:0] q);
      rst      = r;
      pc       = p;
      viol_req = q;
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic episode();
      drive(1'b0, H, 3'b001);
      advance();
      repeat (4) begin
         drive(1'b0, H, 3'b000);
         advance();
      end
   endtask

   initial begin
      // rst, pc, req | reset, cause, episodes, active
      tbl[0]  = '{1'b0, H, 3'b000, 1'b0, 3'b000, 0, 1'b0};
      tbl[1]  = '{1'b0, H, 3'b001, 1'b1, 3'b000, 0, 1'b0};
      tbl[2]  = '{1'b0, H, 3'b000, 1'b1, 3'b001, 1, 1'b1};
      tbl[3]  = '{1'b0, H, 3'b000, 1'b1, 3'b001, 1, 1'b1};
      tbl[4]  = '{1'b0, H, 3'b000, 1'b1, 3'b001, 1, 1'b1};
      tbl[5]  = '{1'b0, H, 3'b000, 1'b1, 3'b001, 1, 1'b1};
      tbl[6]  = '{1'b0, H, 3'b000, 1'b0, 3'b001, 1, 1'b0};
      tbl[7]  = '{1'b0, H, 3'b001, 1'b1, 3'b001, 1, 1'b0};
      tbl[8]  = '{1'b0, H, 3'b000, 1'b1, 3'b001, 2, 1'b1};
      tbl[9]  = '{1'b0, H, 3'b100, 1'b1, 3'b001, 2, 1'b1};
      tbl[10] = '{1'b0, H, 3'b000, 1'b1, 3'b101, 2, 1'b1};
      tbl[11] = '{1'b0, H, 3'b000, 1'b1, 3'b101, 2, 1'b1};
      tbl[12] = '{1'b0, H, 3'b000, 1'b0, 3'b101, 2, 1'b0};
      tbl[13] = '{1'b0, A, 3'b011, 1'b1, 3'b101, 2, 1'b0};
      tbl[14] = '{1'b0, A, 3'b000, 1'b1, 3'b011, 3, 1'b1};
      tbl[15] = '{1'b0, A, 3'b000, 1'b1, 3'b011, 3, 1'b1};
      tbl[16] = '{1'b0, A, 3'b000, 1'b1, 3'b011, 3, 1'b1};
      tbl[17] = '{1'b0, A, 3'b000, 1'b1, 3'b011, 3, 1'b1};
      tbl[18] = '{1'b0, H, 3'b010, 1'b1, 3'b011, 3, 1'b1};
      tbl[19] = '{1'b0, H, 3'b010, 1'b1, 3'b011, 3, 1'b1};
      tbl[20] = '{1'b0, H, 3'b010, 1'b1, 3'b011, 3, 1'b1};
      tbl[21] = '{1'b0, H, 3'b000, 1'b1, 3'b011, 3, 1'b1};
      tbl[22] = '{1'b0, H, 3'b000, 1'b0, 3'b011, 3, 1'b0};
      tbl[23] = '{1'b0, H, 3'b100, 1'b1, 3'b011, 3, 1'b0};
      tbl[24] = '{1'b0, H, 3'b000, 1'b1, 3'b100, 4, 1'b1};
      tbl[25] = '{1'b1, H, 3'b010, 1'b0, 3'b100, 4, 1'b0};
      tbl[26] = '{1'b0, H, 3'b000, 1'b0, 3'b000, 0, 1'b0};

      rst      = 1'b1;
      pc       = H;
      viol_req = 3'b000;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].rst, tbl[i].pc, tbl[i].req);
         check($sformatf("v%0d_reset", i), 32'(reset), 32'(tbl[i].r));
         check($sformatf("v%0d_cause", i), 32'(cause), 32'(tbl[i].c));
         check($sformatf("v%0d_cnt", i), 32'(viol_cnt), 32'(ecnt(tbl[i].n)));
         check($sformatf("v%0d_active", i), 32'(active), 32'(tbl[i].a));
         advance();
      end

      // PC-gated release: pc away from the handler for 20 cycles.
      drive(1'b0, A, 3'b010);
      check("pcg_reset_req", 32'(reset), 32'd1);
      advance();
      for (int i = 1; i < 20; i++) begin
         drive(1'b0, A, 3'b000);
         check($sformatf("pcg_reset_c%0d", i), 32'(reset), 32'd1);
         advance();
      end
      drive(1'b0, H, 3'b000);
      check("pcg_reset_at_handler", 32'(reset), 32'd1);
      advance();
      drive(1'b0, H, 3'b000);
      check("pcg_reset_released", 32'(reset), 32'd0);
      check("pcg_cause", 32'(cause), 32'(3'b010));
      check("pcg_cnt", 32'(viol_cnt), 32'(ecnt(1)));
      advance();

      // Saturation over 300 episodes.
      drive(1'b1, H, 3'b000);
      advance();
      for (int e = 1; e <= 300; e++) begin
         episode();
         if (e == 255) begin
            drive(1'b0, H, 3'b000);
            check("sat_cnt_255", 32'(viol_cnt), 32'(ecnt(255)));
            advance();
         end
      end
      drive(1'b0, H, 3'b000);
      check("sat_cnt_300", 32'(viol_cnt), 32'(ecnt(300)));
      check("sat_reset_low", 32'(reset), 32'd0);
      advance();

      // rst during HOLD abandons the episode.
      drive(1'b0, H, 3'b110);
      advance();
      drive(1'b0, H, 3'b000);
      check("hold_active", 32'(active), 32'd1);
      check("hold_cause", 32'(cause), 32'(3'b110));
      advance();
      drive(1'b1, H, 3'b000);
      check("rst_forces_reset_low", 32'(reset), 32'd0);
      check("rst_forces_active_low", 32'(active), 32'd0);
      advance();
      drive(1'b0, H, 3'b000);
      check("post_rst_reset", 32'(reset), 32'd0);
      check("post_rst_cause", 32'(cause), 32'd0);
      check("post_rst_cnt", 32'(viol_cnt), 32'd0);
      check("post_rst_active", 32'(active), 32'd0);
      advance();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
